cube_frame_receiver: RTL and testbench
======================================

CUBE_FRAME_RECEIVER -- requirements
Module: cube_frame_receiver

Interface
REQ-001 Parameter: LAYER_BITS, 64, serial bits per layer per latch.
REQ-002 Parameter: NUM_LAYERS, 8, layers per frame; one-hot select width.
REQ-003 Port: Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: Reset  input  1  synchronous, active-high reset.
REQ-005 Port: Pins  input  15  cube pin bus: [7:0] layer select one-hot, [8] SER, [9] SCLK, [10] LATCH, [11] OE_n (ignored), [14:12] unused.
REQ-006 Port: Cells  output  512  last complete frame; bit index = layer*64 + bit.
REQ-007 Port: FrameValid  output  1  one-cycle pulse when Cells is updated.
REQ-008 Port: FrameErr  output  1  one-cycle pulse on a rejected latch.
REQ-009 Port: LayerMask  output  8  layers captured in the frame being assembled.

Function
REQ-010 Pins SHALL pass a 2-flop synchronizer; SCLK and LATCH rising edges are detected on the synchronized copies, giving 3-cycle pin-to-action latency.
REQ-011 On each SCLK rising edge, SER SHALL shift into a 64-bit register MSB-first; the first bit shifted lands at bit 63 after 64 shifts.
REQ-012 A 7-bit bit counter SHALL increment per SCLK edge and saturate at 65 (any count >64 means overrun).
REQ-013 On a LATCH rising edge with count == 64 and select one-hot, the shift register SHALL be written to layer buffer slot k (k = index of set select bit) and LayerMask[k] set.
REQ-014 On a LATCH rising edge with count != 64 or select not one-hot (zero or multiple bits), the data SHALL be discarded, FrameErr pulsed for 1 cycle, LayerMask unchanged.
REQ-015 Every LATCH rising edge, valid or not, SHALL clear the bit counter.
REQ-016 SCLK and LATCH edges in the same cycle: the shift SHALL be applied first and the latch SHALL then evaluate the post-shift count and data.
REQ-017 Re-latching an already-captured layer before frame completion SHALL overwrite that slot; LayerMask unchanged.
REQ-018 When LayerMask becomes 8'hFF, the full layer buffer SHALL copy into Cells in the next cycle, FrameValid pulse 1 cycle coincident with the new Cells value, LayerMask return to 0.
REQ-019 Cells SHALL hold its value between frames (double-buffered; partial frames never visible).
REQ-020 State machine: IDLE (count 0) -> SHIFT (first SCLK edge) -> SHIFT (further edges) -> IDLE (LATCH edge); COMMIT entered for 1 cycle when mask is full, then IDLE.
REQ-021 A LATCH edge arriving during COMMIT SHALL be processed normally into the next frame.

Reset
REQ-022 Reset SHALL set Cells=0, FrameValid=0, FrameErr=0, LayerMask=0, bit counter=0, shift register=0, layer buffer=0, synchronizer stages=0, state IDLE.
REQ-023 Reset asserted mid-shift or mid-frame SHALL abandon all partial data; no FrameValid/FrameErr pulse follows release.
REQ-024 Edge detectors SHALL not report an edge in the first cycle after reset release even if SCLK/LATCH are already high.

Structure
REQ-025 Shared package cube_pkg SHALL hold CUBE_DIM=8, LAYER_BITS=64, CELL_COUNT=512 and pin index constants (SEL_LSB/MSB, PIN_SER, PIN_SCLK, PIN_LATCH, PIN_OE_N).
REQ-026 One sub-module pin_sync_edge (2-flop sync plus rising-edge detect, one instance per strobe) SHALL be used; all else in cube_frame_receiver.

Verification
REQ-027 Eight layers, each 64 bits of pattern 64'hA5A5_0000_FFFF_0001 with select 8'h01..8'h80 -> one FrameValid, Cells = that pattern replicated 8x, LayerMask back to 0.
REQ-028 Latch after 63 SCLK edges with select 8'h04 -> FrameErr pulse, LayerMask unchanged, Cells unchanged; repeat with 70 edges -> FrameErr.
REQ-029 Latch with select 8'h03, then 8'h00 -> FrameErr each time, no slot written.
REQ-030 Layer 2 latched with all-ones then all-zeros before frame completion -> final Cells[191:128]=0.
REQ-031 64th SCLK edge and LATCH rising in same cycle -> valid capture, no FrameErr.
REQ-032 Reset after 5 layers and 30 bits of sixth -> outputs 0; new full frame afterwards -> exactly one FrameValid, correct Cells.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared constants, state type and select-decoding helpers for the cube pin-bus receiver.
package cube_pkg;
   localparam int CUBE_DIM   = 8;
   localparam int LAYER_BITS = 64;
   localparam int CELL_COUNT = 512;
   localparam int PIN_WIDTH  = 15;
   localparam int SEL_LSB    = 0;
   localparam int SEL_MSB    = 7;
   localparam int PIN_SER    = 8;
   localparam int PIN_SCLK   = 9;
   localparam int PIN_LATCH  = 10;
   localparam int PIN_OE_N   = 11;
   localparam int CNT_W      = 7;
   localparam logic [CNT_W-1:0] CNT_FULL = 7'd64;
   localparam logic [CNT_W-1:0] CNT_SAT  = 7'd65;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } rx_state_t;

   function automatic logic is_onehot(input logic [CUBE_DIM-1:0] sel);
      return (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
   endfunction

   function automatic logic [2:0] onehot_index(input logic [CUBE_DIM-1:0] sel);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < CUBE_DIM; i++) begin
         if (sel[i]) idx = 3'(i);
      end
      return idx;
   endfunction
endpackage

// File: rtl/pin_sync_edge.sv
// Two-flop synchronizer with rising-edge detect; edges stay masked until the
// history flop holds a real pin sample, so a pin already high at reset release is not an edge.
module pin_sync_edge (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_pin,
   output logic o_rise
);
   logic       r_s1;
   logic       r_s2;
   logic       r_prev;
   logic [2:0] r_arm;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s1   <= 1'b0;
         r_s2   <= 1'b0;
         r_prev <= 1'b0;
         r_arm  <= 3'b000;
      end else begin
         r_s1   <= i_pin;
         r_s2   <= r_s1;
         r_prev <= r_s2;
         r_arm  <= {r_arm[1:0], 1'b1};
      end
   end

   assign o_rise = r_s2 & ~r_prev & r_arm[2];
endmodule

// File: rtl/cube_frame_receiver.sv
// Cube pin-bus receiver: shifts serial layer data, validates latches and publishes
// a double-buffered frame once all layers of the frame have been captured.
module cube_frame_receiver #(
   parameter int LAYER_BITS = cube_pkg::LAYER_BITS,
   parameter int NUM_LAYERS = cube_pkg::CUBE_DIM
) (
   input  logic                             Clk,
   input  logic                             Reset,
   input  logic [cube_pkg::PIN_WIDTH-1:0]   Pins,
   output logic [LAYER_BITS*NUM_LAYERS-1:0] Cells,
   output logic                             FrameValid,
   output logic                             FrameErr,
   output logic [NUM_LAYERS-1:0]            LayerMask
);
   import cube_pkg::*;

   logic [NUM_LAYERS:0]            r_dat_s1;
   logic [NUM_LAYERS:0]            r_dat_s2;
   logic [LAYER_BITS-1:0]          r_shift;
   logic [CNT_W-1:0]               r_cnt;
   logic [NUM_LAYERS-1:0]          r_mask;
   logic [LAYER_BITS*NUM_LAYERS-1:0] r_buf;
   logic [LAYER_BITS*NUM_LAYERS-1:0] r_cells;
   logic                           r_valid;
   logic                           r_err;
   rx_state_t                      r_state;

   logic                  w_sclk_rise;
   logic                  w_latch_rise;
   logic                  w_unused_pins;
   logic [NUM_LAYERS-1:0] w_sel;
   logic                  w_ser;
   logic [LAYER_BITS-1:0] w_shift_next;
   logic [CNT_W-1:0]      w_cnt_next;
   logic                  w_capture;
   logic [2:0]            w_idx;
   logic [NUM_LAYERS-1:0] w_mask_next;

   pin_sync_edge u_sclk  (.i_clk(Clk), .i_reset(Reset), .i_pin(Pins[PIN_SCLK]),  .o_rise(w_sclk_rise));
   pin_sync_edge u_latch (.i_clk(Clk), .i_reset(Reset), .i_pin(Pins[PIN_LATCH]), .o_rise(w_latch_rise));

   assign w_unused_pins = ^Pins[PIN_WIDTH-1:PIN_OE_N];

   // The latch decision sees the post-shift data and count when both strobes coincide
   always_comb begin
      w_sel        = r_dat_s2[NUM_LAYERS-1:0];
      w_ser        = r_dat_s2[NUM_LAYERS];
      w_shift_next = r_shift;
      w_cnt_next   = r_cnt;
      if (w_sclk_rise) begin
         w_shift_next = {r_shift[LAYER_BITS-2:0], w_ser};
         w_cnt_next   = (r_cnt >= CNT_SAT) ? CNT_SAT : (r_cnt + 7'd1);
      end else begin
         w_shift_next = r_shift;
         w_cnt_next   = r_cnt;
      end
      w_capture   = w_latch_rise && (w_cnt_next == CNT_FULL) && is_onehot(w_sel);
      w_idx       = onehot_index(w_sel);
      w_mask_next = (r_state == ST_COMMIT) ? '0 : r_mask;
      if (w_capture) begin
         w_mask_next = w_mask_next | w_sel;
      end else begin
         w_mask_next = w_mask_next;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_dat_s1 <= '0;
         r_dat_s2 <= '0;
         r_shift  <= '0;
         r_cnt    <= '0;
         r_mask   <= '0;
         r_buf    <= '0;
         r_cells  <= '0;
         r_valid  <= 1'b0;
         r_err    <= 1'b0;
         r_state  <= ST_IDLE;
      end else begin
         r_dat_s1 <= {Pins[PIN_SER], Pins[SEL_MSB:SEL_LSB]};
         r_dat_s2 <= r_dat_s1;
         r_shift  <= w_shift_next;
         r_cnt    <= w_latch_rise ? 7'd0 : w_cnt_next;
         r_mask   <= w_mask_next;
         r_err    <= w_latch_rise && !w_capture;
         r_valid  <= (r_state == ST_COMMIT);
         if (r_state == ST_COMMIT) begin
            r_cells <= r_buf;
         end
         if (w_capture) begin
            r_buf[32'(w_idx)*LAYER_BITS +: LAYER_BITS] <= w_shift_next;
         end
         // COMMIT lasts exactly the one cycle in which the mask reads all-ones
         case (r_state)
            ST_IDLE, ST_SHIFT, ST_COMMIT: begin
               if (w_latch_rise) begin
                  r_state <= (w_mask_next == '1) ? ST_COMMIT : ST_IDLE;
               end else if (w_sclk_rise) begin
                  r_state <= ST_SHIFT;
               end else if (r_state == ST_COMMIT) begin
                  r_state <= (r_cnt != 7'd0) ? ST_SHIFT : ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign Cells      = r_cells;
   assign FrameValid = r_valid;
   assign FrameErr   = r_err;
   assign LayerMask  = r_mask;
endmodule

// File: tb/tb_cube_frame_receiver.sv
// Scoreboard bench for cube_frame_receiver: a bit-queue reference model predicts pulses and frames.
module tb_cube_frame_receiver;
   logic         Clk = 1'b0;
   logic         Reset;
   logic [14:0]  Pins;
   logic [511:0] Cells;
   logic         FrameValid;
   logic         FrameErr;
   logic [7:0]   LayerMask;

   localparam logic [63:0] PAT = 64'hA5A5_0000_FFFF_0001;

   typedef struct {
      bit           is_frame;
      logic [511:0] cells;
   } exp_t;

   exp_t         exp_q[$];
   int           total = 0;
   int           bad = 0;
   bit           m_bits[$];
   logic [63:0]  m_layer[8];
   logic [7:0]   m_mask;
   logic [511:0] m_cells;

   always #5 Clk = ~Clk;

   cube_frame_receiver dut (
      .Clk(Clk), .Reset(Reset), .Pins(Pins), .Cells(Cells),
      .FrameValid(FrameValid), .FrameErr(FrameErr), .LayerMask(LayerMask)
   );

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_bits.delete();
      for (int i = 0; i < 8; i++) m_layer[i] = '0;
      m_mask  = '0;
      m_cells = '0;
   endtask

   task automatic model_latch(input logic [7:0] sel);
      exp_t        e;
      logic [63:0] v;
      int          k;
      e.is_frame = 1'b0;
      e.cells    = '0;
      if (m_bits.size() == 64 && $countones(sel) == 1) begin
         v = '0;
         for (int i = 0; i < 64; i++) v[63-i] = m_bits[i];
         k = 0;
         for (int i = 0; i < 8; i++) if (sel[i]) k = i;
         m_layer[k] = v;
         m_mask[k]  = 1'b1;
         if (m_mask == 8'hFF) begin
            e.is_frame = 1'b1;
            for (int j = 0; j < 8; j++) e.cells[j*64 +: 64] = m_layer[j];
            m_cells = e.cells;
            m_mask  = '0;
            exp_q.push_back(e);
         end
      end else begin
         exp_q.push_back(e);
      end
      m_bits.delete();
   endtask

   task automatic drive(input logic [7:0] sel, input bit ser, input bit sclk, input bit latch);
      @(negedge Clk);
      Pins = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), latch, sclk, ser, sel};
   endtask

   task automatic send_bit(input bit b, input logic [7:0] sel, input bit with_latch);
      drive(sel, b, 1'b0, 1'b0);
      drive(sel, b, 1'b1, with_latch);
      m_bits.push_back(b);
      if (with_latch) model_latch(sel);
   endtask

   task automatic do_latch(input logic [7:0] sel);
      drive(sel, 1'b0, 1'b0, 1'b0);
      drive(sel, 1'b0, 1'b0, 1'b1);
      model_latch(sel);
   endtask

   task automatic send_layer(input logic [63:0] v, input logic [7:0] sel, input bit merged);
      for (int i = 0; i < 64; i++) send_bit(v[63-i], sel, merged && (i == 63));
      if (!merged) do_latch(sel);
   endtask

   task automatic send_bits(input int n, input logic [7:0] sel);
      for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), sel, 1'b0);
   endtask

   task automatic inject_noise();
      int         pick;
      logic [7:0] sel;
      pick = $urandom_range(0, 2);
      sel  = (pick == 0) ? 8'h00 : (pick == 1) ? 8'h81 : (8'h01 << $urandom_range(0, 7));
      send_bits($urandom_range(58, 70), sel);
      do_latch(sel);
   endtask

   task automatic settle();
      int n;
      n = 0;
      repeat (8) drive(8'h00, 1'b0, 1'b0, 1'b0);
      while (exp_q.size() != 0 && n < 50) begin
         drive(8'h00, 1'b0, 1'b0, 1'b0);
         n++;
      end
      check("drain_outstanding", 512'(exp_q.size()), 512'd0);
      exp_q.delete();
      check("layer_mask", LayerMask, m_mask);
      check("cells_hold", Cells, m_cells);
   endtask

   task automatic do_reset(input bit hold_high);
      @(negedge Clk);
      Reset = 1'b1;
      Pins  = hold_high ? 15'h0600 : 15'h0000;
      repeat (3) @(negedge Clk);
      check("rst_cells", Cells, 512'd0);
      check("rst_mask", LayerMask, 512'd0);
      check("rst_valid", FrameValid, 512'd0);
      check("rst_err", FrameErr, 512'd0);
      Reset = 1'b0;
      model_reset();
      exp_q.delete();
   endtask

   // Monitor: every pulse must match the next predicted event
   always @(negedge Clk) begin
      exp_t e;
      if (!Reset && (FrameValid || FrameErr)) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse: valid=%0b err=%0b expected no pulse", FrameValid, FrameErr);
         end else begin
            e = exp_q.pop_front();
            check("pulse_kind", {FrameValid, FrameErr}, e.is_frame ? 512'd2 : 512'd1);
            if (e.is_frame) check("frame_cells", Cells, e.cells);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached before finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[8];
      int j;
      int t;
      Pins  = '0;
      Reset = 1'b1;
      model_reset();
      do_reset(1'b1);
      repeat (6) @(negedge Clk);
      Pins = '0;
      settle();

      // Full frame of the fixed pattern
      for (int l = 0; l < 8; l++) send_layer(PAT, 8'h01 << l, 1'b0);
      settle();
      check("pattern_x8", Cells, {8{PAT}});

      // Short / overrun counts and bad selects with layer 0 pending
      send_layer(64'h0123_4567_89AB_CDEF, 8'h01, 1'b0);
      send_bits(63, 8'h04);
      do_latch(8'h04);
      settle();
      send_bits(70, 8'h04);
      do_latch(8'h04);
      settle();
      send_bits(64, 8'h03);
      do_latch(8'h03);
      send_bits(64, 8'h00);
      do_latch(8'h00);
      settle();

      // Layer 2 rewritten before completion
      send_layer(64'h1111_2222_3333_4444, 8'h02, 1'b0);
      send_layer('1, 8'h04, 1'b0);
      send_layer('0, 8'h04, 1'b0);
      for (int l = 3; l < 8; l++) send_layer({$urandom, $urandom}, 8'h01 << l, 1'b0);
      settle();
      check("layer2_zero", Cells[191:128], 512'd0);

      // 64th clock edge coincident with the latch edge
      for (int l = 0; l < 8; l++) send_layer({$urandom, $urandom}, 8'h01 << l, 1'b1);
      settle();

      // Reset partway through a frame, then a fresh frame
      for (int l = 0; l < 5; l++) send_layer({$urandom, $urandom}, 8'h01 << l, 1'b0);
      send_bits(30, 8'h20);
      do_reset(1'b0);
      settle();
      for (int l = 0; l < 8; l++) send_layer({$urandom, $urandom}, 8'h01 << l, 1'b0);
      settle();

      // Randomized frames: shuffled layer order, merged latches, injected noise
      for (int f = 0; f < 6; f++) begin
         for (int i = 0; i < 8; i++) order[i] = i;
         for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = order[i];
            order[i] = order[j];
            order[j] = t;
         end
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 4) == 0) inject_noise();
            send_layer({$urandom, $urandom}, 8'h01 << order[i], $urandom_range(0, 2) == 0);
         end
         settle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
